// File: rtl/writeback_step_pkg.sv
// writeback_step_pkg: shared memOp encodings, writeback FSM states and datapath width default
package writeback_step_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LBU = 4'd4,
    OP_LHU = 4'd5,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } mem_op_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_LOAD, S_COMMIT} state_e;
endpackage

// File: rtl/writeback_step_load_align_extend.sv
// load_align_extend: selects the addressed byte/halfword of a load word, extends it and flags misalignment
module load_align_extend
  import writeback_step_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      memop_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        is_b, is_h;
  always_comb begin
    b = offset_i == 2'd0 ? word_i[7:0] :
        offset_i == 2'd1 ? word_i[15:8] :
        offset_i == 2'd2 ? word_i[23:16] : word_i[31:24];
    h = offset_i[1] ? word_i[31:16] : word_i[15:0];
    is_b = memop_i == OP_LB || memop_i == OP_LBU;
    is_h = memop_i == OP_LH || memop_i == OP_LHU;
    data_o = memop_i == OP_LB  ? {{(XLEN-8){b[7]}}, b} :
             memop_i == OP_LBU ? {{(XLEN-8){1'b0}}, b} :
             memop_i == OP_LH  ? {{(XLEN-16){h[15]}}, h} :
             memop_i == OP_LHU ? {{(XLEN-16){1'b0}}, h} : word_i;
    misalign_o = is_b ? 1'b0 : is_h ? offset_i[0] : offset_i != 2'd0;
  end
endmodule

// File: rtl/writeback_step.sv
// writeback_step: final pipeline stage; retires ALU results and loads into the register file, stalls on pending loads
module writeback_step
  import writeback_step_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_step_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [3:0]            memOp_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic                  load_valid_i,
  input  logic [XLEN-1:0]       load_data_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  output logic [XLEN-1:0]       rf_data_o,
  output logic                  misalign_o,
  output logic [CNT_W-1:0]      retired_o
);
  state_e                state_q, state_d;
  logic [3:0]            memop_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [1:0]            off_q;
  logic                  got_data_q;
  logic [XLEN-1:0]       ld_data_q;
  logic                  we_q, we_d, mis_q, mis_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [XLEN-1:0]       ext;
  logic                  ext_mis, acc, commit, load_done;
  assign ready_o   = state_q != S_WAIT_LOAD;
  assign acc       = valid_i && ready_o && enable_step_i;
  assign commit    = state_q == S_COMMIT && enable_step_i;
  assign load_done = state_q == S_WAIT_LOAD && enable_step_i && (got_data_q || load_valid_i);
  assign rf_we_o    = commit && we_q;
  assign misalign_o = commit && mis_q;
  assign rf_addr_o  = addr_q;
  assign rf_data_o  = data_q;
  assign retired_o  = cnt_q;
  load_align_extend #(.XLEN(XLEN)) u_align (
    .memop_i   (memop_q),
    .offset_i  (off_q),
    .word_i    (got_data_q ? ld_data_q : load_data_i),
    .data_o    (ext),
    .misalign_o(ext_mis)
  );
  always_comb begin
    state_d = acc ? (mem_read_i ? S_WAIT_LOAD : S_COMMIT) :
              commit ? S_IDLE :
              load_done ? S_COMMIT : state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    mis_d   = mis_q;
    if (acc && !mem_read_i) begin
      addr_d = rd_i;
      data_d = alu_result_i;
      we_d   = !mem_write_i && rd_i != '0;
      mis_d  = 1'b0;
    end else if (load_done) begin
      addr_d = rd_q;
      data_d = ext;
      we_d   = !ext_mis && rd_q != '0;
      mis_d  = ext_mis;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      memop_q    <= '0;
      rd_q       <= '0;
      off_q      <= '0;
      got_data_q <= 1'b0;
      ld_data_q  <= '0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      if (acc) begin
        memop_q <= memOp_i;
        rd_q    <= rd_i;
        off_q   <= alu_result_i[1:0];
      end
      got_data_q <= state_q == S_WAIT_LOAD && state_d == S_WAIT_LOAD && (got_data_q || load_valid_i);
      if (state_q == S_WAIT_LOAD && load_valid_i && !got_data_q) ld_data_q <= load_data_i;
      if (commit && !mis_q) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_writeback_step.sv
// tb_writeback_step: table-driven and directed checks of writeback_step with a commit scoreboard
module tb_writeback_step;
  import writeback_step_pkg::*;
  logic        clk_i = 1'b0, rst_i = 1'b1, enable_step_i = 1'b1, valid_i = 1'b0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0, load_valid_i = 1'b0;
  logic [3:0]  memOp_i = '0;
  logic [4:0]  rd_i = '0;
  logic [31:0] alu_result_i = '0, load_data_i = '0;
  logic        ready_o, rf_we_o, misalign_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o, retired_o;
  writeback_step dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_step_i(enable_step_i), .valid_i(valid_i),
    .ready_o(ready_o), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .memOp_i(memOp_i),
    .rd_i(rd_i), .alu_result_i(alu_result_i), .load_valid_i(load_valid_i),
    .load_data_i(load_data_i), .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
    .rf_data_o(rf_data_o), .misalign_o(misalign_o), .retired_o(retired_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {logic [4:0] addr; logic [31:0] data; bit mis;} exp_t;
  typedef struct {
    bit ld; bit st; logic [3:0] op; logic [4:0] rd; logic [31:0] alu;
    logic [31:0] word; int lat; logic [31:0] data; bit mis;
  } vec_t;
  exp_t sb[$];
  vec_t v[12];
  int checks = 0, errors = 0, ret = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk_i) begin
    if (rst_i && (rf_we_o || misalign_o)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: we=%b mis=%b addr=%0d data=%h expected no commit",
                 rf_we_o, misalign_o, rf_addr_o, rf_data_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_mis", 32'(misalign_o), 32'(e.mis));
        chk("commit_we", 32'(rf_we_o), 32'(!e.mis));
        if (!e.mis) begin
          chk("commit_addr", 32'(rf_addr_o), 32'(e.addr));
          chk("commit_data", rf_data_o, e.data);
        end
      end
    end
  end
  task automatic drive(input bit ld, input bit st, input logic [3:0] op, input logic [4:0] rd,
                       input logic [31:0] alu);
    valid_i = 1'b1; mem_read_i = ld; mem_write_i = st; memOp_i = op; rd_i = rd; alu_result_i = alu;
  endtask
  task automatic do_reset();
    @(posedge clk_i); #1 rst_i = 1'b0;
    #2;
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_we", 32'(rf_we_o), 0);
    chk("rst_addr", 32'(rf_addr_o), 0);
    chk("rst_data", rf_data_o, 0);
    chk("rst_mis", 32'(misalign_o), 0);
    chk("rst_retired", retired_o, 0);
    ret = 0;
    @(posedge clk_i); #1 rst_i = 1'b1;
  endtask
  initial begin
    bit vis;
    v[0]  = '{0, 0, OP_LW,  5'd5,  32'h1234_5678, 32'h0,         0, 32'h1234_5678, 0};
    v[1]  = '{1, 0, OP_LB,  5'd6,  32'h0000_1003, 32'h80FF_0000, 3, 32'hFFFF_FF80, 0};
    v[2]  = '{1, 0, OP_LBU, 5'd6,  32'h0000_1003, 32'h80FF_0000, 3, 32'h0000_0080, 0};
    v[3]  = '{1, 0, OP_LH,  5'd8,  32'h0000_2001, 32'hFFFF_FFFF, 1, 32'h0,         1};
    v[4]  = '{1, 0, OP_LW,  5'd9,  32'h0000_1000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0};
    v[5]  = '{1, 0, OP_LH,  5'd10, 32'h0000_0002, 32'h8001_1234, 2, 32'hFFFF_8001, 0};
    v[6]  = '{1, 0, OP_LHU, 5'd11, 32'h0000_0002, 32'h8001_1234, 1, 32'h0000_8001, 0};
    v[7]  = '{1, 0, OP_LB,  5'd12, 32'h0000_0001, 32'h0000_7F00, 0, 32'h0000_007F, 0};
    v[8]  = '{1, 0, OP_LW,  5'd13, 32'h0000_0002, 32'h1111_2222, 1, 32'h0,         1};
    v[9]  = '{1, 0, 4'd3,   5'd14, 32'h0000_0000, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 0};
    v[10] = '{0, 1, OP_SW,  5'd7,  32'h0000_0040, 32'h0,         0, 32'h0,         0};
    v[11] = '{1, 0, OP_LB,  5'd0,  32'h0000_0002, 32'h00AB_0000, 1, 32'h0,         0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      chk("ready_idle", 32'(ready_o), 1);
      drive(v[i].ld, v[i].st, v[i].op, v[i].rd, v[i].alu);
      vis = !v[i].st && (v[i].mis || v[i].rd != 0);
      if (vis) sb.push_back('{v[i].rd, v[i].data, v[i].mis});
      if (!v[i].mis) ret++;
      @(posedge clk_i); #1 valid_i = 1'b0;
      if (v[i].ld) begin
        for (int k = 0; k < v[i].lat; k++) begin
          @(negedge clk_i); chk("ready_stall", 32'(ready_o), 0);
          @(posedge clk_i); #1;
        end
        load_valid_i = 1'b1; load_data_i = v[i].word;
        @(posedge clk_i); #1 load_valid_i = 1'b0; load_data_i = 32'h5555_5555;
      end
      @(negedge clk_i); chk("commit_visible", 32'(rf_we_o || misalign_o), 32'(vis));
      @(posedge clk_i); #1; chk("retired", retired_o, ret);
    end
    do_reset();
    drive(0, 0, OP_LW, 5'd0, 32'h100);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) sb.push_back('{5'(i), 32'h100 + 32'(i), 0});
      @(posedge clk_i); #1;
      if (i < 3) drive(0, 0, OP_LW, 5'(i + 1), 32'h100 + 32'(i + 1));
      else valid_i = 1'b0;
      @(negedge clk_i); chk("b2b_we", 32'(rf_we_o), 32'(i != 0));
    end
    @(posedge clk_i); #1; chk("b2b_retired", retired_o, 4);
    ret = 4;
    drive(1, 0, OP_LW, 5'd9, 32'h0);
    sb.push_back('{5'd9, 32'hA5A5_0F0F, 0});
    @(posedge clk_i); #1 valid_i = 1'b0; enable_step_i = 1'b0;
    load_valid_i = 1'b1; load_data_i = 32'hA5A5_0F0F;
    @(posedge clk_i); #1 load_valid_i = 1'b0; load_data_i = 32'h0;
    @(negedge clk_i); chk("dis_wait_ready", 32'(ready_o), 0); chk("dis_wait_we", 32'(rf_we_o), 0);
    @(posedge clk_i); #1 enable_step_i = 1'b1;
    @(negedge clk_i); chk("en_rise_we", 32'(rf_we_o), 0);
    @(posedge clk_i); #1;
    @(negedge clk_i); chk("held_load_commit", 32'(rf_we_o), 1);
    @(posedge clk_i); #1;
    @(negedge clk_i); chk("single_commit", 32'(rf_we_o), 0);
    ret++;
    chk("held_load_retired", retired_o, ret);
    drive(0, 0, OP_LW, 5'd12, 32'h0000_A5A5);
    sb.push_back('{5'd12, 32'h0000_A5A5, 0});
    @(posedge clk_i); #1 enable_step_i = 1'b0; drive(0, 0, OP_LW, 5'd13, 32'hBAD);
    @(negedge clk_i); chk("dis_commit_we", 32'(rf_we_o), 0); chk("dis_ready", 32'(ready_o), 1);
    @(posedge clk_i); #1;
    @(negedge clk_i); chk("dis_commit_we2", 32'(rf_we_o), 0);
    @(posedge clk_i); #1 enable_step_i = 1'b1; valid_i = 1'b0;
    @(negedge clk_i); chk("en_commit_we", 32'(rf_we_o), 1);
    @(posedge clk_i); #1;
    @(negedge clk_i); chk("en_commit_once", 32'(rf_we_o), 0);
    ret++;
    chk("en_commit_retired", retired_o, ret);
    drive(1, 0, OP_LW, 5'd9, 32'h0);
    @(posedge clk_i); #1 valid_i = 1'b0; rst_i = 1'b0;
    #2;
    chk("abort_ready", 32'(ready_o), 1);
    chk("abort_retired", retired_o, 0);
    rst_i = 1'b1;
    load_valid_i = 1'b1; load_data_i = 32'h7777_7777;
    @(posedge clk_i); #1 load_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); chk("abort_we", 32'(rf_we_o), 0); chk("abort_data", rf_data_o, 0);
    end
    chk("abort_retired_end", retired_o, 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
